uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Parametrised UART transmit framer: accepts parallel words over a valid/ready handshake
//  and serialises each as start, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
//  Bit timing comes from an external one-cycle baud_tick strobe.
//  A one-deep holding register allows back-to-back frames with no idle gap.
//  Sits between the host/FIFO interface and the tx pad; replaces the bare line-select mux.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame, legal 5..9
//  CNT_W        $clog2(DATA_WIDTH)  bit-counter width (derived, do not override)
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  reset_n      in   1            synchronous, active-low reset
//  baud_tick    in   1            one-clk pulse per bit period
//  tx_valid     in   1            host has a word on tx_data
//  tx_ready     out  1            holding register empty; transfer when tx_valid && tx_ready
//  tx_data      in   DATA_WIDTH   word to send
//  parity_en    in   1            1 = insert parity bit
//  parity_odd   in   1            0 = even, 1 = odd parity
//  two_stop     in   1            1 = two stop bits
//  tx_serial    out  1            serial line, idle high (registered)
//  tx_busy      out  1            frame in progress (state != IDLE)
//  tx_done      out  1            one-clk pulse when last stop bit period ends
// BEHAVIOUR
//  Reset (clk edge with reset_n=0): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE,
//   holding register empty, counters 0; any frame in flight is aborted, buffered word discarded.
//  Handshake: tx_ready = !hold_full (from register, no comb path from tx_valid). Accept loads
//   tx_data into hold and sets hold_full. tx_data need only be stable in the accept cycle.
//  FSM states IDLE, START, DATA, PARITY, STOP. Transitions happen only in baud_tick cycles;
//   tx_serial updates on the same edge, so each bit is held exactly one tick period.
//  IDLE:   tx_serial=1. On baud_tick with hold_full: hold->shift reg, hold_full=0,
//          latch parity_en/parity_odd/two_stop, parity acc=0, -> START, tx_serial=0.
//  START:  on tick -> DATA, drive shift[0], bit_cnt=0.
//  DATA:   on tick: bit_cnt==DATA_WIDTH-1 ? (parity_en ? PARITY : STOP) : next bit, bit_cnt+1.
//          Parity bit = XOR(data bits) ^ parity_odd.
//  PARITY: on tick -> STOP, tx_serial=1, stop_cnt=0.
//  STOP:   on tick: if two_stop && stop_cnt==0 -> stay, stop_cnt=1; else pulse tx_done and
//          -> START (tx_serial=0, reload from hold) if hold_full, else -> IDLE (tx_serial=1).
//  Latency: word accepted in IDLE -> start bit appears after the next baud_tick edge.
//  Config inputs sampled only at frame load; changes mid-frame affect the next frame only.
//  Accept and load in the same cycle cannot happen (ready=0 while hold_full); accept in the
//   cycle after load is legal, giving back-to-back frames.
//  baud_tick while reset_n=0 is ignored. baud_tick held high = one bit per clk (legal, test use).
//  tx_done and STOP->START reload may coincide; tx_busy stays 1 across back-to-back frames.
// STRUCTURE
//  uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP); constants
//   UART_IDLE_BIT=1'b1, UART_START_BIT=1'b0, UART_STOP_BIT=1'b1; tx line-select encoding.
//  One sub-module: uart_tx_line_mux - registered select of idle/start/data/parity/stop bit,
//   reset to idle-high, update enable = baud_tick. FSM, hold reg, shift reg, counters in top.
// TESTING (DATA_WIDTH=8, baud_tick every 16 clk unless stated)
//  1 reset_n=0 for 3 clk mid-traffic -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
//  2 send 0x55, parity off, 1 stop -> line per tick: 0,1,0,1,0,1,0,1,0,1; tx_done after 10 ticks.
//  3 send 0xA3, parity_en=1: even -> parity bit 0, odd -> 1; two_stop=1 -> 12 bit periods.
//  4 tx_valid held with 0x01 then 0x80 -> second start bit directly after first stop, no idle
//    period; tx_busy stays 1; tx_ready low from 2nd accept until 2nd frame loads.
//  5 reset_n=0 during data bit 3 with word buffered -> tx_serial=1 next clk, word never sent.
//  6 toggle parity_en mid-frame -> current frame unchanged, next frame uses new setting.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit framer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_START,
    SEL_DATA,
    SEL_PARITY,
    SEL_STOP
  } line_sel_t;

  localparam logic UART_IDLE_BIT  = 1'b1;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_line_mux.sv
// Registered serial-line driver: picks idle/start/data/parity/stop level, updates only on baud_tick.
module uart_tx_line_mux
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  line_sel_t sel,
  input  logic      data_bit,
  input  logic      parity_bit,
  output logic      line
);

  logic line_next;

  always_comb begin
    line_next = UART_IDLE_BIT;
    case (sel)
      SEL_IDLE:   line_next = UART_IDLE_BIT;
      SEL_START:  line_next = UART_START_BIT;
      SEL_DATA:   line_next = data_bit;
      SEL_PARITY: line_next = parity_bit;
      SEL_STOP:   line_next = UART_STOP_BIT;
      default:    line_next = UART_IDLE_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line <= UART_IDLE_BIT;
    end else if (tick) begin
      line <= line_next;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-deep holding register, start/data/parity/stop sequencing on baud_tick.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  tx_state_t             state;
  tx_state_t             state_next;
  line_sel_t             line_sel;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  par_acc;
  logic                  cfg_parity_en;
  logic                  cfg_parity_odd;
  logic                  cfg_two_stop;
  logic                  accept;
  logic                  load;
  logic                  frame_end;
  logic                  last_bit;
  logic                  shift_en;

  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid && !hold_full;
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  // Each data bit leaves shift[0] on the tick that starts its period.
  assign shift_en = baud_tick && ((state == START) || (state == DATA && !last_bit));

  always_comb begin
    state_next = state;
    line_sel   = SEL_IDLE;
    load       = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (baud_tick && hold_full) begin
          load       = 1'b1;
          state_next = START;
          line_sel   = SEL_START;
        end
      end
      START: begin
        if (baud_tick) begin
          state_next = DATA;
          line_sel   = SEL_DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (!last_bit) begin
            line_sel = SEL_DATA;
          end else if (cfg_parity_en) begin
            state_next = PARITY;
            line_sel   = SEL_PARITY;
          end else begin
            state_next = STOP;
            line_sel   = SEL_STOP;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_next = STOP;
          line_sel   = SEL_STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (cfg_two_stop && !stop_cnt) begin
            line_sel = SEL_STOP;
          end else begin
            frame_end = 1'b1;
            if (hold_full) begin
              load       = 1'b1;
              state_next = START;
              line_sel   = SEL_START;
            end else begin
              state_next = IDLE;
              line_sel   = SEL_IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state   <= state_next;
      tx_done <= frame_end;
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
      if (baud_tick && state == START) begin
        bit_cnt <= '0;
      end else if (baud_tick && state == DATA && !last_bit) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state_next == STOP && state != STOP) begin
        stop_cnt <= 1'b0;
      end else if (baud_tick && state == STOP) begin
        stop_cnt <= 1'b1;
      end
    end
  end

  // Datapath: word buffer, shifter, running parity and per-frame config snapshot.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= tx_data;
    end
    if (load) begin
      shift          <= hold_data;
      par_acc        <= 1'b0;
      cfg_parity_en  <= parity_en;
      cfg_parity_odd <= parity_odd;
      cfg_two_stop   <= two_stop;
    end else if (shift_en) begin
      shift   <= shift >> 1;
      par_acc <= par_acc ^ shift[0];
    end
  end

  uart_tx_line_mux u_line_mux (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (baud_tick),
    .sel        (line_sel),
    .data_bit   (shift[0]),
    .parity_bit (par_acc ^ cfg_parity_odd),
    .line       (tx_serial)
  );

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame shapes, parity, stop bits, back-to-back, reset abort.
module tb_uart_tx_framer;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int   errors = 0;
  int   checks = 0;
  int   div = 0;
  logic tick_always = 1'b0;

  uart_tx_framer #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial baud_tick = 1'b0;
  always @(posedge clk) begin
    #2;
    if (tick_always) begin
      baud_tick = 1'b1;
    end else begin
      baud_tick = (div == 15);
      div = (div == 15) ? 0 : div + 1;
    end
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after the next tick edge.
  task automatic wait_tick();
    int n = 0;
    while (!baud_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!baud_tick) check("tick_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                            input logic podd, input logic two, input logic [11:0] exp,
                            input int nbits, input int flip_at);
    wait_ready();
    tx_data    = data;
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      wait_tick();
      check($sformatf("%s_bit%0d", tag, i), tx_serial, exp[i]);
      if (i == 0) check($sformatf("%s_busy", tag), tx_busy, 1'b1);
      if (i == nbits - 1) check($sformatf("%s_nodone", tag), tx_done, 1'b0);
      if (i == flip_at) parity_en = !parity_en;
    end
    wait_tick();
    check($sformatf("%s_done", tag), tx_done, 1'b1);
    check($sformatf("%s_idle", tag), tx_serial, 1'b1);
    check($sformatf("%s_notbusy", tag), tx_busy, 1'b0);
  endtask

  initial begin
    logic [11:0] f1;
    logic [11:0] f2;
    reset_n    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    reset_n = 1'b1;

    send_frame("t2_55", 8'h55, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h55, 1'b0}, 10, -1);
    send_frame("t3_even", 8'hA3, 1'b1, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 8'hA3, 1'b0}, 12, -1);
    send_frame("t3_odd", 8'hA3, 1'b1, 1'b1, 1'b1, {1'b1, 1'b1, 1'b1, 8'hA3, 1'b0}, 12, -1);

    tick_always = 1'b1;
    send_frame("held_5a", 8'h5A, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, -1);
    tick_always = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back: tx_valid stays high across the first load.
    f1 = {2'b00, 1'b1, 8'h01, 1'b0};
    f2 = {2'b00, 1'b1, 8'h80, 1'b0};
    wait_ready();
    parity_en = 1'b0;
    two_stop  = 1'b0;
    tx_data   = 8'h01;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_data = 8'h80;
    check("t4_ready_low_1st", tx_ready, 1'b0);
    wait_tick();
    check("t4_f1_bit0", tx_serial, f1[0]);
    check("t4_ready_after_load", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_ready_low_2nd", tx_ready, 1'b0);
    for (int i = 1; i < 10; i++) begin
      wait_tick();
      check($sformatf("t4_f1_bit%0d", i), tx_serial, f1[i]);
      check($sformatf("t4_f1_busy%0d", i), tx_busy, 1'b1);
    end
    wait_tick();
    check("t4_f1_done", tx_done, 1'b1);
    check("t4_f2_bit0", tx_serial, f2[0]);
    check("t4_busy_across", tx_busy, 1'b1);
    check("t4_ready_after_reload", tx_ready, 1'b1);
    for (int i = 1; i < 10; i++) begin
      wait_tick();
      check($sformatf("t4_f2_bit%0d", i), tx_serial, f2[i]);
    end
    wait_tick();
    check("t4_f2_done", tx_done, 1'b1);
    check("t4_f2_idle", tx_serial, 1'b1);
    check("t4_f2_notbusy", tx_busy, 1'b0);

    // Reset held 3 clk in the middle of a frame.
    wait_ready();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) wait_tick();
    check("t1_pre_low", tx_serial, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_serial", tx_serial, 1'b1);
    check("t1_ready", tx_ready, 1'b1);
    check("t1_busy", tx_busy, 1'b0);
    check("t1_done", tx_done, 1'b0);
    reset_n = 1'b1;
    repeat (2) wait_tick();
    check("t1_aborted", tx_busy, 1'b0);

    // Reset during data bit 3 with a second word buffered.
    wait_ready();
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h0F;
    wait_tick();
    check("t5_start", tx_serial, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t5_buffered", tx_ready, 1'b0);
    repeat (4) wait_tick();
    check("t5_d3", tx_serial, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_serial_next", tx_serial, 1'b1);
    check("t5_ready", tx_ready, 1'b1);
    check("t5_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      check($sformatf("t5_never_sent%0d", i), tx_serial, 1'b1);
      check($sformatf("t5_idle_busy%0d", i), tx_busy, 1'b0);
    end

    // Parity enable flipped mid-frame applies from the following frame.
    send_frame("t6_a", 8'h3C, 1'b0, 1'b0, 1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 3);
    check("t6_pen_flipped", parity_en, 1'b1);
    send_frame("t6_b", 8'h07, parity_en, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
